// File: rtl/id_ex_pipeline_register.sv
// ID/EX pipeline register: captures the decoded control bundle and operands, turning
// Stall/Flush/invalid entries into zeroed bubbles. Define ID_EX_PERF_EN for bubble/instruction counters.
module id_ex_pipeline_register #(
    parameter int unsigned DATA_W = 64
`ifdef ID_EX_PERF_EN
    ,
    parameter int unsigned CNT_W = 32
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              Freeze,
    input  logic              Flush,
    input  logic              Stall,
    input  logic              ValidIn,
    input  logic              ALUSrcIn,
    input  logic              MemtoRegIn,
    input  logic              RegWriteIn,
    input  logic              MemReadIn,
    input  logic              MemWriteIn,
    input  logic              BranchIn,
    input  logic [1:0]        ALUOpIn,
    input  logic [DATA_W-1:0] PCIn,
    input  logic [DATA_W-1:0] ReadData1In,
    input  logic [DATA_W-1:0] ReadData2In,
    input  logic [DATA_W-1:0] ImmIn,
    input  logic [4:0]        Rs1In,
    input  logic [4:0]        Rs2In,
    input  logic [4:0]        RdIn,
    input  logic [3:0]        Funct4In,
    output logic              ValidOut,
    output logic              ALUSrcOut,
    output logic              MemtoRegOut,
    output logic              RegWriteOut,
    output logic              MemReadOut,
    output logic              MemWriteOut,
    output logic              BranchOut,
    output logic [1:0]        ALUOpOut,
    output logic [DATA_W-1:0] PCOut,
    output logic [DATA_W-1:0] ReadData1Out,
    output logic [DATA_W-1:0] ReadData2Out,
    output logic [DATA_W-1:0] ImmOut,
    output logic [4:0]        Rs1Out,
    output logic [4:0]        Rs2Out,
    output logic [4:0]        RdOut,
    output logic [3:0]        Funct4Out
`ifdef ID_EX_PERF_EN
    ,
    output logic [CNT_W-1:0]  BubbleCount,
    output logic [CNT_W-1:0]  InstCount
`endif
);

    typedef struct packed {
        logic              valid;
        logic              alu_src;
        logic              mem_to_reg;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
        logic              branch;
        logic [1:0]        alu_op;
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] rd1;
        logic [DATA_W-1:0] rd2;
        logic [DATA_W-1:0] imm;
        logic [4:0]        rs1;
        logic [4:0]        rs2;
        logic [4:0]        rd;
        logic [3:0]        funct4;
    } id_ex_t;

    id_ex_t entry_in;
    id_ex_t entry_d;
    id_ex_t entry_q;
    logic   bubble;

    always_comb begin
        entry_in = '{
            valid:      1'b1,
            alu_src:    ALUSrcIn,
            mem_to_reg: MemtoRegIn,
            reg_write:  RegWriteIn,
            mem_read:   MemReadIn,
            mem_write:  MemWriteIn,
            branch:     BranchIn,
            alu_op:     ALUOpIn,
            pc:         PCIn,
            rd1:        ReadData1In,
            rd2:        ReadData2In,
            imm:        ImmIn,
            rs1:        Rs1In,
            rs2:        Rs2In,
            rd:         RdIn,
            funct4:     Funct4In
        };
    end

    // A bubble zeroes the whole entry regardless of what Control_Unit drove.
    assign bubble = Flush | Stall | ~ValidIn;

    always_comb begin
        entry_d = entry_q;
        if (!Freeze) begin
            if (bubble) begin
                entry_d = '0;
            end else begin
                entry_d = entry_in;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            entry_q <= '0;
        end else begin
            entry_q <= entry_d;
        end
    end

    assign ValidOut     = entry_q.valid;
    assign ALUSrcOut    = entry_q.alu_src;
    assign MemtoRegOut  = entry_q.mem_to_reg;
    assign RegWriteOut  = entry_q.reg_write;
    assign MemReadOut   = entry_q.mem_read;
    assign MemWriteOut  = entry_q.mem_write;
    assign BranchOut    = entry_q.branch;
    assign ALUOpOut     = entry_q.alu_op;
    assign PCOut        = entry_q.pc;
    assign ReadData1Out = entry_q.rd1;
    assign ReadData2Out = entry_q.rd2;
    assign ImmOut       = entry_q.imm;
    assign Rs1Out       = entry_q.rs1;
    assign Rs2Out       = entry_q.rs2;
    assign RdOut        = entry_q.rd;
    assign Funct4Out    = entry_q.funct4;

`ifdef ID_EX_PERF_EN
    logic [CNT_W-1:0] bubble_cnt_d;
    logic [CNT_W-1:0] bubble_cnt_q;
    logic [CNT_W-1:0] inst_cnt_d;
    logic [CNT_W-1:0] inst_cnt_q;

    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        inst_cnt_d   = inst_cnt_q;
        if (!Freeze) begin
            if (bubble) begin
                bubble_cnt_d = bubble_cnt_q + 1'b1;
            end else begin
                inst_cnt_d = inst_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bubble_cnt_q <= '0;
            inst_cnt_q   <= '0;
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
            inst_cnt_q   <= inst_cnt_d;
        end
    end

    assign BubbleCount = bubble_cnt_q;
    assign InstCount   = inst_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_pipeline_register.sv
// Self-checking bench for id_ex_pipeline_register: directed test-plan steps followed by
// randomized cycles against a rule-level reference model. Counter checks need ID_EX_PERF_EN.
module tb_id_ex_pipeline_register;

    localparam int unsigned CW = 4;

    logic        clk = 1'b0;
    logic        reset, Freeze, Flush, Stall, ValidIn;
    logic        ALUSrcIn, MemtoRegIn, RegWriteIn, MemReadIn, MemWriteIn, BranchIn;
    logic [1:0]  ALUOpIn;
    logic [63:0] PCIn, ReadData1In, ReadData2In, ImmIn;
    logic [4:0]  Rs1In, Rs2In, RdIn;
    logic [3:0]  Funct4In;
    logic        ValidOut, ALUSrcOut, MemtoRegOut, RegWriteOut, MemReadOut, MemWriteOut, BranchOut;
    logic [1:0]  ALUOpOut;
    logic [63:0] PCOut, ReadData1Out, ReadData2Out, ImmOut;
    logic [4:0]  Rs1Out, Rs2Out, RdOut;
    logic [3:0]  Funct4Out;
`ifdef ID_EX_PERF_EN
    logic [CW-1:0] BubbleCount, InstCount;
`endif

    always #5 clk = ~clk;

    id_ex_pipeline_register #(
        .DATA_W(64)
`ifdef ID_EX_PERF_EN
        ,
        .CNT_W(CW)
`endif
    ) dut (
        .clk(clk), .reset(reset), .Freeze(Freeze), .Flush(Flush), .Stall(Stall), .ValidIn(ValidIn),
        .ALUSrcIn(ALUSrcIn), .MemtoRegIn(MemtoRegIn), .RegWriteIn(RegWriteIn),
        .MemReadIn(MemReadIn), .MemWriteIn(MemWriteIn), .BranchIn(BranchIn), .ALUOpIn(ALUOpIn),
        .PCIn(PCIn), .ReadData1In(ReadData1In), .ReadData2In(ReadData2In), .ImmIn(ImmIn),
        .Rs1In(Rs1In), .Rs2In(Rs2In), .RdIn(RdIn), .Funct4In(Funct4In),
        .ValidOut(ValidOut), .ALUSrcOut(ALUSrcOut), .MemtoRegOut(MemtoRegOut),
        .RegWriteOut(RegWriteOut), .MemReadOut(MemReadOut), .MemWriteOut(MemWriteOut),
        .BranchOut(BranchOut), .ALUOpOut(ALUOpOut), .PCOut(PCOut), .ReadData1Out(ReadData1Out),
        .ReadData2Out(ReadData2Out), .ImmOut(ImmOut), .Rs1Out(Rs1Out), .Rs2Out(Rs2Out),
        .RdOut(RdOut), .Funct4Out(Funct4Out)
`ifdef ID_EX_PERF_EN
        ,
        .BubbleCount(BubbleCount), .InstCount(InstCount)
`endif
    );

    // Reference model: what EX should hold, plus plain event tallies for the counters.
    typedef struct {
        logic        valid, alusrc, memtoreg, regwrite, memread, memwrite, branch;
        logic [1:0]  aluop;
        logic [63:0] pc, rd1, rd2, imm;
        logic [4:0]  rs1, rs2, rd;
        logic [3:0]  f4;
    } ex_t;

    ex_t         exp_e;
    ex_t         snap;
    int unsigned exp_bub;
    int unsigned exp_inst;
    int unsigned n_vec;
    int unsigned n_err;

    function automatic ex_t zero_entry();
        ex_t e;
        e = '{valid: 1'b0, alusrc: 1'b0, memtoreg: 1'b0, regwrite: 1'b0, memread: 1'b0,
              memwrite: 1'b0, branch: 1'b0, aluop: 2'b00, pc: 64'h0, rd1: 64'h0, rd2: 64'h0,
              imm: 64'h0, rs1: 5'd0, rs2: 5'd0, rd: 5'd0, f4: 4'h0};
        return e;
    endfunction

    function automatic ex_t observed_inputs();
        ex_t e;
        e = '{valid: 1'b1, alusrc: ALUSrcIn, memtoreg: MemtoRegIn, regwrite: RegWriteIn,
              memread: MemReadIn, memwrite: MemWriteIn, branch: BranchIn, aluop: ALUOpIn,
              pc: PCIn, rd1: ReadData1In, rd2: ReadData2In, imm: ImmIn,
              rs1: Rs1In, rs2: Rs2In, rd: RdIn, f4: Funct4In};
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic check_all(input ex_t e);
        chk("ValidOut", {63'h0, ValidOut}, {63'h0, e.valid});
        chk("ALUSrcOut", {63'h0, ALUSrcOut}, {63'h0, e.alusrc});
        chk("MemtoRegOut", {63'h0, MemtoRegOut}, {63'h0, e.memtoreg});
        chk("RegWriteOut", {63'h0, RegWriteOut}, {63'h0, e.regwrite});
        chk("MemReadOut", {63'h0, MemReadOut}, {63'h0, e.memread});
        chk("MemWriteOut", {63'h0, MemWriteOut}, {63'h0, e.memwrite});
        chk("BranchOut", {63'h0, BranchOut}, {63'h0, e.branch});
        chk("ALUOpOut", {62'h0, ALUOpOut}, {62'h0, e.aluop});
        chk("PCOut", PCOut, e.pc);
        chk("ReadData1Out", ReadData1Out, e.rd1);
        chk("ReadData2Out", ReadData2Out, e.rd2);
        chk("ImmOut", ImmOut, e.imm);
        chk("Rs1Out", {59'h0, Rs1Out}, {59'h0, e.rs1});
        chk("Rs2Out", {59'h0, Rs2Out}, {59'h0, e.rs2});
        chk("RdOut", {59'h0, RdOut}, {59'h0, e.rd});
        chk("Funct4Out", {60'h0, Funct4Out}, {60'h0, e.f4});
`ifdef ID_EX_PERF_EN
        chk("BubbleCount", {60'h0, BubbleCount}, 64'(exp_bub % (1 << CW)));
        chk("InstCount", {60'h0, InstCount}, 64'(exp_inst % (1 << CW)));
`endif
    endtask

    // One clock edge: apply the priority rules to the inputs present at the edge, then compare.
    task automatic step();
        @(posedge clk);
        if (reset) begin
            exp_e    = zero_entry();
            exp_bub  = 0;
            exp_inst = 0;
        end else if (!Freeze) begin
            if (Flush || Stall || !ValidIn) begin
                exp_e = zero_entry();
                exp_bub++;
            end else begin
                exp_e = observed_inputs();
                exp_inst++;
            end
        end
        #1;
        check_all(exp_e);
    endtask

    task automatic rand_payload();
        ALUSrcIn    = 1'($urandom_range(0, 1));
        MemtoRegIn  = 1'($urandom_range(0, 1));
        RegWriteIn  = 1'($urandom_range(0, 1));
        MemReadIn   = 1'($urandom_range(0, 1));
        MemWriteIn  = 1'($urandom_range(0, 1));
        BranchIn    = 1'($urandom_range(0, 1));
        ALUOpIn     = 2'($urandom_range(0, 3));
        PCIn        = {$urandom, $urandom};
        ReadData1In = {$urandom, $urandom};
        ReadData2In = {$urandom, $urandom};
        ImmIn       = {$urandom, $urandom};
        Rs1In       = 5'($urandom_range(0, 31));
        Rs2In       = 5'($urandom_range(0, 31));
        RdIn        = 5'($urandom_range(0, 31));
        Funct4In    = 4'($urandom_range(0, 15));
    endtask

    task automatic ctrl(input logic r, input logic fz, input logic fl, input logic st, input logic v);
        reset = r; Freeze = fz; Flush = fl; Stall = st; ValidIn = v;
    endtask

    initial begin
        n_vec = 0; n_err = 0; exp_bub = 0; exp_inst = 0;
        exp_e = zero_entry();
        rand_payload();
        ctrl(1, 0, 0, 0, 1);

        // Reset state
        step();
        step();

        // R-type load
        ctrl(0, 0, 0, 0, 1);
        rand_payload();
        RegWriteIn = 1'b1; ALUOpIn = 2'b10; RdIn = 5'd5; ReadData1In = 64'h10;
        MemReadIn = 1'b0; MemWriteIn = 1'b0;
        step();
        chk("rtype_regwrite", {63'h0, RegWriteOut}, 64'd1);
        chk("rtype_aluop", {62'h0, ALUOpOut}, 64'd2);
        chk("rtype_rd", {59'h0, RdOut}, 64'd5);
        chk("rtype_rd1", ReadData1Out, 64'h10);
        chk("rtype_valid", {63'h0, ValidOut}, 64'd1);

        // ld with Stall: bubble despite forced nonzero controls
        rand_payload();
        MemReadIn = 1'b1; MemtoRegIn = 1'b1; RegWriteIn = 1'b1; ALUSrcIn = 1'b1; RdIn = 5'd7;
        ctrl(0, 0, 0, 1, 1);
        step();
        chk("stall_memread", {63'h0, MemReadOut}, 64'd0);
        chk("stall_rd", {59'h0, RdOut}, 64'd0);
        chk("stall_valid", {63'h0, ValidOut}, 64'd0);
`ifdef ID_EX_PERF_EN
        chk("stall_bubcnt", {60'h0, BubbleCount}, 64'd1);
`endif

        // Back-to-back stalls, then Flush+Stall together with sd inputs
        step();
        rand_payload();
        MemWriteIn = 1'b1;
        ctrl(0, 0, 1, 1, 1);
        step();
        chk("flushstall_memwrite", {63'h0, MemWriteOut}, 64'd0);
        chk("flushstall_valid", {63'h0, ValidOut}, 64'd0);
`ifdef ID_EX_PERF_EN
        chk("flushstall_bubcnt", {60'h0, BubbleCount}, 64'd3);
`endif

        // Valid addi, then Freeze for 3 edges with changing inputs and Flush
        rand_payload();
        ALUSrcIn = 1'b1; RegWriteIn = 1'b1; ALUOpIn = 2'b00; ImmIn = 64'h7ff;
        ctrl(0, 0, 0, 0, 1);
        step();
        snap = exp_e;
        for (int unsigned i = 0; i < 3; i++) begin
            rand_payload();
            ctrl(0, 1, 1, 1'($urandom_range(0, 1)), 1);
            step();
            check_all(snap);
        end

        // Reset on the same edge as Freeze, valid data held
        ctrl(1, 1, 0, 0, 1);
        step();
        check_all(zero_entry());
`ifdef ID_EX_PERF_EN
        chk("rst_freeze_inst", {60'h0, InstCount}, 64'd0);
`endif

        // 16 valid instructions: 4-bit InstCount wraps to 0
        for (int unsigned i = 0; i < 16; i++) begin
            rand_payload();
            ctrl(0, 0, 0, 0, 1);
            step();
        end
`ifdef ID_EX_PERF_EN
        chk("wrap_inst", {60'h0, InstCount}, 64'd0);
        chk("wrap_bub", {60'h0, BubbleCount}, 64'd0);
`endif

        // Randomized mix of all controls
        for (int unsigned i = 0; i < 400; i++) begin
            rand_payload();
            ctrl(($urandom_range(0, 99) < 3), ($urandom_range(0, 99) < 20),
                 ($urandom_range(0, 99) < 15), ($urandom_range(0, 99) < 15),
                 ($urandom_range(0, 99) < 85));
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/id_ex_pipeline_register.md
# id_ex_pipeline_register

Pipeline register between the Decode stage (Control_Unit, register file, immediate generator) and the Execute stage. Each cycle it captures the decoded control bundle and operand data, unless it is frozen, flushed or stalled. It converts stalls and flushes into clean bubbles so that EX, MEM and WB see no side effects. It is the only storage point for control signals entering EX.

## Interface
- DATA_W, 64, width of PC, register-read and immediate fields
- CNT_W, 32, width of performance counters (only with ID_EX_PERF_EN)

- clk  in  1  pipeline clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; clears all state
- Freeze  in  1  global hold; register keeps current contents
- Flush  in  1  taken-branch squash; next captured entry is a bubble
- Stall  in  1  load-use stall (same signal driven to Control_Unit); next captured entry is a bubble
- ValidIn  in  1  IF/ID entry holds a real instruction
- ALUSrcIn, MemtoRegIn, RegWriteIn, MemReadIn, MemWriteIn, BranchIn  in  1 each  control bundle from Control_Unit
- ALUOpIn  in  2  ALU operation class
- PCIn, ReadData1In, ReadData2In, ImmIn  in  DATA_W each  decode operands
- Rs1In, Rs2In, RdIn  in  5 each  register indices
- Funct4In  in  4  {instr[30], instr[14:12]} for the ALU control
- ALUSrcOut … BranchOut, ALUOpOut, PCOut, ReadData1Out, ReadData2Out, ImmOut, Rs1Out, Rs2Out, RdOut, Funct4Out  out  same widths  registered copies
- ValidOut  out  1  EX entry is a real instruction
- BubbleCount  out  CNT_W  bubbles inserted (ID_EX_PERF_EN only)
- InstCount  out  CNT_W  valid instructions passed (ID_EX_PERF_EN only)

## Operation
- One cycle is evaluated per rising edge. Priority: reset > Freeze > Flush > Stall > normal load.
- reset: every output, including the counters, goes to 0. ALUOpOut resets to 2'b00.
- Freeze: all outputs and counters hold. Flush and Stall asserted during Freeze are ignored. The upstream logic must hold them until Freeze deasserts.
- Bubble (Flush=1, or Stall=1, or ValidIn=0):
  - All control outputs and ALUOpOut are cleared to 0; ValidOut=0.
  - RdOut, Rs1Out and Rs2Out are cleared to 0, so forwarding and hazard logic see x0.
  - Data fields are cleared to 0.
  - The bubble is forced even if the control inputs are nonzero; the register does not rely on Control_Unit having zeroed them.
- Normal load: every *Out takes its *In value; ValidOut=1.
- Flush and Stall together: a single bubble is inserted; the result is identical to Flush alone.
- Control values are passed through without decoding; X on MemtoRegIn is passed through.

## Timing
- Latency is 1 cycle from the inputs to the outputs. There is no combinational path from any input to any output.
- Reset asserted mid-stream takes effect at the next edge and overrides Freeze. The first edge after reset deasserts captures normally.
- Freeze held for N cycles holds the outputs for N cycles. The first edge with Freeze=0 applies that cycle's inputs, Flush and Stall.
- A bubble occupies exactly one EX slot per qualifying edge. Back-to-back Stall cycles produce back-to-back bubbles.

## Configuration
- ID_EX_PERF_EN defined:
  - BubbleCount increments on each non-frozen, non-reset edge that captures a bubble.
  - InstCount increments on each non-frozen, non-reset edge that captures a valid instruction.
  - Both wrap modulo 2^CNT_W and are cleared by reset.
- ID_EX_PERF_EN undefined: the counters, their ports and their logic are absent. All other behaviour is identical.

## Test plan
- Reset, then R-type load (RegWriteIn=1, ALUOpIn=2'b10, RdIn=5, ReadData1In=64'h10) -> after 1 edge RegWriteOut=1, ALUOpOut=2'b10, RdOut=5, ReadData1Out=64'h10, ValidOut=1.
- ld instruction with Stall=1 and MemReadIn=1 forced -> after 1 edge all controls are 0, RdOut=0, ValidOut=0; BubbleCount=1 with ID_EX_PERF_EN.
- Flush=1 and Stall=1 on the same edge with sd inputs (MemWriteIn=1) -> MemWriteOut=0, ValidOut=0, and BubbleCount increments by exactly 1.
- Valid addi loaded, then Freeze=1 for 3 edges with changing inputs and Flush=1 -> outputs unchanged for 3 edges; the Flush is ignored and the counters are unchanged.
- Reset asserted on the same edge as Freeze=1, with valid data held -> all outputs and counters are 0 after that edge.
- With CNT_W=4, send 16 valid instructions -> InstCount wraps to 0 and BubbleCount stays 0.
